pool_stream: RTL and testbench

- Streaming 2-D pooling unit; successor to the fixed 6x6x3 combinational 2x2 max-pool stage.
- Accepts one pixel per beat in raster order, with all channels packed in the pixel, over a valid/ready handshake.
- Window size, feature-map size, channel count, data width and signedness are parameters. Max or average mode is selected per frame.
- Sits between the conv output stage and the next layer. A one-row line buffer replaces the full-frame flattened input bus.

---
 rtl/pool_stream.sv | 209 ++++++++++++++++++++
 tb/tb_pool_stream.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pool_stream.sv
// Streaming KxK pooling unit (max or average) over a valid/ready pixel stream.
// Pixels arrive in raster order with all C channels packed in one beat. A
// per-channel horizontal accumulator folds the K pixels of a window row, and
// a line buffer of W/K partial results folds the K rows. The finished window
// value is written into a single output register that can be refilled on the
// same edge it is consumed.
module pool_stream #(
    parameter int W      = 6,
    parameter int H      = 6,
    parameter int C      = 3,
    parameter int DW     = 8,
    parameter int K      = 2,
    parameter int SIGNED = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mode,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [C*DW-1:0] in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [C*DW-1:0] out_data,
    output logic            out_last,
    output logic            busy
);

    localparam int LK  = $clog2(K);
    localparam int SH  = 2 * LK;
    localparam int AW  = DW + SH;
    localparam int NWX = W / K;
    localparam int CW  = (W > 1) ? $clog2(W) : 1;
    localparam int RW  = (H > 1) ? $clog2(H) : 1;
    localparam int XW  = (NWX > 1) ? $clog2(NWX) : 1;
    localparam logic [CW-1:0] COL_LAST = CW'(W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(H - 1);
    localparam logic [LK-1:0] K_LAST   = LK'(K - 1);
    localparam bit IS_SIGNED = (SIGNED != 0);

    // Widen an element to accumulator width, keeping its numeric value.
    function automatic logic [AW-1:0] extend(input logic [DW-1:0] e);
        if (IS_SIGNED) begin
            return {{SH{e[DW-1]}}, e};
        end else begin
            return {{SH{1'b0}}, e};
        end
    endfunction

    // Pooling operator: sum in average mode, larger of the two in max mode.
    function automatic logic [AW-1:0] combine(input logic [AW-1:0] a,
                                              input logic [AW-1:0] b,
                                              input logic          avg);
        logic a_gt_b;
        if (IS_SIGNED) begin
            a_gt_b = ($signed(a) > $signed(b));
        end else begin
            a_gt_b = (a > b);
        end
        if (avg) begin
            return a + b;
        end else if (a_gt_b) begin
            return a;
        end else begin
            return b;
        end
    endfunction

    // Final scaling: the window sum divided by K*K with floor rounding.
    function automatic logic [DW-1:0] convert(input logic [AW-1:0] v, input logic avg);
        if (!avg) begin
            return DW'(v);
        end else if (IS_SIGNED) begin
            return DW'($signed(v) >>> SH);
        end else begin
            return DW'(v >> SH);
        end
    endfunction

    logic [CW-1:0]   col_r;
    logic [RW-1:0]   row_r;
    logic            mode_r;
    logic [AW-1:0]   hacc_r [C];
    logic [AW-1:0]   lbuf_r [NWX][C];
    logic            out_valid_r;
    logic [C*DW-1:0] out_data_r;
    logic            out_last_r;
    logic            busy_r;

    logic            accept_s;
    logic            first_s;
    logic            eff_mode_s;
    logic            win_done_s;
    logic            frame_end_s;
    logic [LK-1:0]   kc_s;
    logic [LK-1:0]   kr_s;
    logic [XW-1:0]   wx_s;
    logic [AW-1:0]   elem_s [C];
    logic [AW-1:0]   hsum_s [C];
    logic [AW-1:0]   line_s [C];
    logic [C*DW-1:0] conv_s;

    assign in_ready    = !out_valid_r || out_ready;
    assign accept_s    = in_valid && in_ready;
    assign first_s     = (col_r == '0) && (row_r == '0);
    // The first beat of a frame uses the live mode input; later beats the latched copy.
    assign eff_mode_s  = first_s ? mode : mode_r;
    assign kc_s        = col_r[LK-1:0];
    assign kr_s        = row_r[LK-1:0];
    assign wx_s        = XW'(col_r >> LK);
    assign win_done_s  = accept_s && (kc_s == K_LAST) && (kr_s == K_LAST);
    assign frame_end_s = (col_r == COL_LAST) && (row_r == ROW_LAST);

    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_last  = out_last_r;
    assign busy      = busy_r;

    // Per-channel window arithmetic for the current beat.
    always_comb begin
        conv_s = '0;
        for (int ch = 0; ch < C; ch++) begin
            elem_s[ch] = extend(in_data[ch*DW +: DW]);
            hsum_s[ch] = combine(hacc_r[ch], elem_s[ch], eff_mode_s);
            if (kr_s == '0) begin
                line_s[ch] = hsum_s[ch];
            end else begin
                line_s[ch] = combine(lbuf_r[wx_s][ch], hsum_s[ch], eff_mode_s);
            end
            conv_s[ch*DW +: DW] = convert(line_s[ch], eff_mode_s);
        end
    end

    // Raster position counters and the per-frame mode latch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_r  <= '0;
            row_r  <= '0;
            mode_r <= 1'b0;
        end else if (accept_s) begin
            if (first_s) begin
                mode_r <= mode;
            end
            if (col_r == COL_LAST) begin
                col_r <= '0;
                if (row_r == ROW_LAST) begin
                    row_r <= '0;
                end else begin
                    row_r <= row_r + 1'b1;
                end
            end else begin
                col_r <= col_r + 1'b1;
            end
        end
    end

    // Horizontal accumulator: restarts at the left edge of every window.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int ch = 0; ch < C; ch++) begin
                hacc_r[ch] <= '0;
            end
        end else if (accept_s) begin
            for (int ch = 0; ch < C; ch++) begin
                if (kc_s == '0) begin
                    hacc_r[ch] <= elem_s[ch];
                end else begin
                    hacc_r[ch] <= hsum_s[ch];
                end
            end
        end
    end

    // Line buffer of partial window results; the first window row overwrites stale data.
    always_ff @(posedge clk) begin
        if (accept_s && (kc_s == K_LAST) && (kr_s != K_LAST)) begin
            for (int ch = 0; ch < C; ch++) begin
                lbuf_r[wx_s][ch] <= line_s[ch];
            end
        end
    end

    // Output register: a new window result wins over a same-edge consume.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_last_r  <= 1'b0;
        end else if (win_done_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= conv_s;
            out_last_r  <= frame_end_s;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
        end
    end

    // Frame-in-progress flag: set by a frame's first beat, cleared when its last output leaves.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_r <= 1'b0;
        end else if (accept_s && first_s) begin
            busy_r <= 1'b1;
        end else if (out_valid_r && out_ready && out_last_r) begin
            busy_r <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pool_stream.sv
// Bench for pool_stream: an unsigned and a signed instance share one input
// stream; a window-level reference model predicts every pooled pixel.
module tb_pool_stream;

    localparam int W = 6;
    localparam int H = 6;
    localparam int C = 3;
    localparam int DW = 8;
    localparam int K = 2;
    localparam int NPIX = W * H;

    typedef struct packed {
        logic [C*DW-1:0] data;
        logic            last;
    } beat_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            mode = 1'b0;
    logic            in_valid = 1'b0;
    logic            out_ready = 1'b0;
    logic [C*DW-1:0] in_data = '0;

    logic            in_ready_u, out_valid_u, out_last_u, busy_u;
    logic [C*DW-1:0] out_data_u;
    logic            in_ready_s, out_valid_s, out_last_s, busy_s;
    logic [C*DW-1:0] out_data_s;

    beat_t exp_u[$];
    beat_t exp_s[$];
    beat_t got_u[$];
    beat_t got_s[$];
    beat_t cur_u, cur_s;

    int checks = 0;
    int failures = 0;
    int or_mode = 0;

    logic [C*DW-1:0] frame_pix [NPIX];
    logic            frame_mode;

    pool_stream #(.W(W), .H(H), .C(C), .DW(DW), .K(K), .SIGNED(0)) dut_u (
        .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid), .in_ready(in_ready_u),
        .in_data(in_data), .out_valid(out_valid_u), .out_ready(out_ready),
        .out_data(out_data_u), .out_last(out_last_u), .busy(busy_u)
    );

    pool_stream #(.W(W), .H(H), .C(C), .DW(DW), .K(K), .SIGNED(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid), .in_ready(in_ready_s),
        .in_data(in_data), .out_valid(out_valid_s), .out_ready(out_ready),
        .out_data(out_data_s), .out_last(out_last_s), .busy(busy_s)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic int floor_div(input int s, input int n);
        int q;
        q = s / n;
        if ((s % n != 0) && (s < 0)) q = q - 1;
        return q;
    endfunction

    // Reference: pool every KxK window of the stored frame for both signedness views.
    task automatic model_frame();
        beat_t bu, bs;
        int su, ss, mu, ms, eu, es, ru, rs;
        logic [DW-1:0] e;
        for (int wy = 0; wy < H / K; wy++) begin
            for (int wx = 0; wx < W / K; wx++) begin
                bu.data = '0;
                bs.data = '0;
                for (int ch = 0; ch < C; ch++) begin
                    su = 0; ss = 0; mu = -1; ms = -1000;
                    for (int dy = 0; dy < K; dy++) begin
                        for (int dx = 0; dx < K; dx++) begin
                            e  = frame_pix[(wy*K + dy)*W + wx*K + dx][ch*DW +: DW];
                            eu = int'(e);
                            es = int'($signed(e));
                            su += eu;
                            ss += es;
                            if (eu > mu) mu = eu;
                            if (es > ms) ms = es;
                        end
                    end
                    ru = frame_mode ? floor_div(su, K*K) : mu;
                    rs = frame_mode ? floor_div(ss, K*K) : ms;
                    bu.data[ch*DW +: DW] = ru[DW-1:0];
                    bs.data[ch*DW +: DW] = rs[DW-1:0];
                end
                bu.last = (wy == H/K - 1) && (wx == W/K - 1);
                bs.last = bu.last;
                exp_u.push_back(bu);
                exp_s.push_back(bs);
            end
        end
    endtask

    // kind 0 random, 1 ramp 36*d+6*r+c, 2 average corner cases, 3 signed max corner case
    task automatic gen_frame(input int kind, input logic m);
        int r, c, v;
        frame_mode = m;
        for (int i = 0; i < NPIX; i++) begin
            r = i / W;
            c = i % W;
            for (int ch = 0; ch < C; ch++) begin
                case (kind)
                    1:       v = 36*ch + 6*r + c;
                    default: v = $urandom_range(0, 255);
                endcase
                frame_pix[i][ch*DW +: DW] = v[DW-1:0];
            end
        end
        if (kind == 2) begin
            frame_pix[0][7:0]   = 8'd10;  frame_pix[1][7:0]   = 8'd11;
            frame_pix[W][7:0]   = 8'd12;  frame_pix[W+1][7:0] = 8'd13;
            frame_pix[0][15:8]  = 8'hFF;  frame_pix[1][15:8]  = 8'hFE;
            frame_pix[W][15:8]  = 8'hFF;  frame_pix[W+1][15:8] = 8'hFF;
            frame_pix[0][23:16] = 8'hFF;  frame_pix[1][23:16] = 8'hFF;
            frame_pix[W][23:16] = 8'hFF;  frame_pix[W+1][23:16] = 8'hFF;
        end
        if (kind == 3) begin
            frame_pix[0][7:0] = 8'h80;  frame_pix[1][7:0]   = 8'h01;
            frame_pix[W][7:0] = 8'h7F;  frame_pix[W+1][7:0] = 8'hFF;
        end
        model_frame();
    endtask

    // Drive nbeats pixels of the stored frame; mode is randomised after the first beat.
    task automatic send_frame(input int nbeats, input bit gaps);
        int i, guard;
        bit acc;
        i = 0;
        guard = 0;
        while (i < nbeats) begin
            in_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_data  = frame_pix[i];
            mode     = (i == 0) ? frame_mode : 1'($urandom_range(0, 1));
            @(negedge clk);
            acc = in_valid && in_ready_u;
            @(posedge clk);
            #1;
            if (acc) begin
                if (i == 0) chk("busy_rise", busy_u, 1);
                i++;
                guard = 0;
            end else begin
                guard++;
                if (guard > 200) begin
                    chk("input_stall_timeout", guard, 0);
                    break;
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((exp_u.size() != 0 || exp_s.size() != 0) && g < 500) begin
            @(posedge clk);
            #1;
            g++;
        end
        chk("drain_timeout", g < 500, 1);
        chk("idle_busy_u", busy_u, 0);
        chk("idle_busy_s", busy_s, 0);
        chk("idle_out_valid", out_valid_u, 0);
    endtask

    // Downstream acceptance policy: 0 always ready, 1 random, 2 stalled.
    always @(posedge clk) begin
        #1;
        case (or_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 2) != 0);
            default: out_ready = 1'b0;
        endcase
    end

    // Compare every consumed output against the model, in order.
    always @(negedge clk) begin
        if (rst_n && out_valid_u && out_ready) begin
            chk("pending_u", exp_u.size() > 0, 1);
            if (exp_u.size() > 0) begin
                cur_u = exp_u.pop_front();
                chk("data_u", out_data_u, cur_u.data);
                chk("last_u", out_last_u, cur_u.last);
            end
            got_u.push_back({out_data_u, out_last_u});
        end
        if (rst_n && out_valid_s && out_ready) begin
            chk("pending_s", exp_s.size() > 0, 1);
            if (exp_s.size() > 0) begin
                cur_s = exp_s.pop_front();
                chk("data_s", out_data_s, cur_s.data);
                chk("last_s", out_last_s, cur_s.last);
            end
            got_s.push_back({out_data_s, out_last_s});
        end
    end

    initial begin
        int nlast;
        int g;
        logic [C*DW-1:0] held;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid_u, 0);
        chk("rst_busy", busy_u, 0);
        chk("rst_in_ready", in_ready_u, 1);
        chk("rst_out_last", out_last_u, 0);
        chk("rst_out_data", out_data_u, 0);
        rst_n = 1'b1;

        // Ramp frame, max mode.
        got_u.delete(); got_s.delete();
        gen_frame(1, 1'b0);
        chk("model_ramp_first", exp_u[0].data, {8'd79, 8'd43, 8'd7});
        chk("model_ramp_lastwin", exp_u[8].data, {8'd107, 8'd71, 8'd35});
        chk("model_ramp_lastflag", exp_u[8].last, 1);
        send_frame(NPIX, 1'b0);
        drain();
        chk("ramp_count", got_u.size(), 9);
        chk("ramp_first", got_u[0].data, {8'd79, 8'd43, 8'd7});
        chk("ramp_lastwin", got_u[8].data, {8'd107, 8'd71, 8'd35});
        nlast = 0;
        foreach (got_u[i]) nlast += got_u[i].last;
        chk("ramp_last_count", nlast, 1);
        chk("ramp_last_pos", got_u[8].last, 1);

        // Average corner windows, both signedness views.
        got_u.delete(); got_s.delete();
        gen_frame(2, 1'b1);
        chk("model_avg_u", exp_u[0].data, {8'd255, 8'hFE, 8'd11});
        chk("model_avg_s", exp_s[0].data, {8'hFF, 8'hFE, 8'd11});
        send_frame(NPIX, 1'b0);
        drain();
        chk("avg_u", got_u[0].data, {8'd255, 8'hFE, 8'd11});
        chk("avg_s", got_s[0].data, {8'hFF, 8'hFE, 8'd11});

        // Max of 0x80,0x01,0x7F,0xFF.
        got_u.delete(); got_s.delete();
        gen_frame(3, 1'b0);
        send_frame(NPIX, 1'b0);
        drain();
        chk("max_unsigned", got_u[0].data[7:0], 8'hFF);
        chk("max_signed", got_s[0].data[7:0], 8'h7F);

        // Backpressure after the first output.
        got_u.delete(); got_s.delete();
        gen_frame(0, 1'($urandom_range(0, 1)));
        or_mode = 2;
        fork
            send_frame(NPIX, 1'b0);
            begin
                g = 0;
                while (!out_valid_u && g < 300) begin
                    @(negedge clk);
                    g++;
                end
                chk("bp_wait", g < 300, 1);
                held = out_data_u;
                repeat (10) begin
                    @(negedge clk);
                    chk("bp_in_ready", in_ready_u, 0);
                    chk("bp_hold", out_data_u, held);
                end
                or_mode = 0;
            end
        join
        drain();
        chk("bp_count", got_u.size(), 9);

        // Back-to-back: average frame then max frame, mode toggled mid-frame.
        gen_frame(0, 1'b1);
        send_frame(NPIX, 1'b0);
        gen_frame(0, 1'b0);
        send_frame(NPIX, 1'b0);
        drain();

        // Random frames with input and output gaps.
        or_mode = 1;
        for (int f = 0; f < 6; f++) begin
            gen_frame(0, 1'($urandom_range(0, 1)));
            send_frame(NPIX, 1'b1);
        end
        drain();

        // Reset mid-frame, then a fresh ramp frame.
        or_mode = 0;
        @(posedge clk);
        #1;
        gen_frame(1, 1'b0);
        send_frame(20, 1'b0);
        chk("mid_out_valid", out_valid_u, 1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_out_valid", out_valid_u, 0);
        chk("mid_rst_busy", busy_u, 0);
        exp_u.delete(); exp_s.delete();
        rst_n = 1'b1;
        got_u.delete(); got_s.delete();
        gen_frame(1, 1'b0);
        send_frame(NPIX, 1'b0);
        drain();
        chk("fresh_count", got_u.size(), 9);
        chk("fresh_first", got_u[0].data, {8'd79, 8'd43, 8'd7});
        chk("fresh_lastwin", got_u[8].data, {8'd107, 8'd71, 8'd35});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
